pwm_cfg_sequencer: RTL and testbench

Wishbone master that sits directly upstream of the PWM/timer slave port. It accepts register-write commands (address, data) from a local controller over a valid/ready stream and buffers them in a small FIFO. It then issues them one at a time as classic single Wishbone write cycles. Each cycle is closed on ack or aborted on timeout, and the block records a sticky error with the failing address.

---
 rtl/pwm_cfg_sequencer_if.sv | 27 ++
 rtl/pwm_cfg_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_cfg_sequencer_if.sv
// Command stream and Wishbone master signals of the PWM configuration sequencer.
// The master modport is the sequencer's view. The slave modport is the view of
// the environment around it: the local controller plus the PWM/timer slave.
interface pwm_cfg_sequencer_if;
  // Command stream from the local controller
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [15:0] i_cmd_adr;
  logic [15:0] i_cmd_data;
  // Classic Wishbone write bus towards the PWM/timer slave
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [15:0] o_wb_adr;
  logic [15:0] o_wb_data;
  logic        i_wb_ack;

  modport master (
    input  i_cmd_valid, i_cmd_adr, i_cmd_data, i_wb_ack,
    output o_cmd_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data
  );

  modport slave (
    output i_cmd_valid, i_cmd_adr, i_cmd_data, i_wb_ack,
    input  o_cmd_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data
  );
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// PWM configuration sequencer.
// Register-write commands are buffered in a small FIFO. Each command is issued
// as a single classic Wishbone write. A cycle ends on ack, or it is aborted after
// TIMEOUT cycles without ack, which leaves a sticky error and the failing address.
module pwm_cfg_sequencer #(
  parameter int FIFO_DEPTH = 4,   // power of two, >= 2
  parameter int TIMEOUT    = 15   // 1..255
) (
  input  logic                     i_wb_clk,
  input  logic                     i_wb_rst,
  pwm_cfg_sequencer_if.master      bus,
  input  logic                     i_err_clr,
  output logic                     o_busy,
  output logic                     o_err,
  output logic [15:0]              o_err_adr,
  output logic [7:0]               o_wr_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]    TMO_C   = 8'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_GAP} state_e;

  logic [15:0]   fifo_adr_q  [FIFO_DEPTH];
  logic [15:0]   fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic [15:0]   adr_q, adr_d;
  logic [15:0]   data_q, data_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [15:0]   err_adr_q, err_adr_d;
  logic [7:0]    wr_cnt_q, wr_cnt_d;

  logic full, empty, push, pop;

  // A full FIFO refuses a push even when the sequencer pops in the same cycle.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign push  = bus.i_cmd_valid && !full;
  assign pop   = (state_q == ST_IDLE) && !empty;

  // FIFO pointer and occupancy update
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage: payload only, validity is tracked by the pointers and count
  always_ff @(posedge i_wb_clk) begin
    // NOTE: the storage array has no reset; an emptied count makes stale entries unreachable.
    if (push) begin
      fifo_adr_q[wr_ptr_q]  <= bus.i_cmd_adr;
      fifo_data_q[wr_ptr_q] <= bus.i_cmd_data;
    end
  end

  // Bus sequencer: IDLE loads the head command, BUS waits for ack or timeout, GAP idles one cycle
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    err_adr_d = err_adr_q;
    wr_cnt_d  = wr_cnt_q;

    // The clear is applied first so a timeout in the same cycle overrides it.
    if (i_err_clr) err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          adr_d   = fifo_adr_q[rd_ptr_q];
          data_d  = fifo_data_q[rd_ptr_q];
          tmo_d   = '0;
        end
      end
      ST_BUS: begin
        if (bus.i_wb_ack) begin
          state_d  = ST_GAP;
          cyc_d    = 1'b0;
          wr_cnt_d = wr_cnt_q + 8'd1;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TMO_C) begin
            // Abort: the command is dropped, not retried.
            state_d   = ST_GAP;
            cyc_d     = 1'b0;
            err_d     = 1'b1;
            err_adr_d = adr_q;
          end
        end
      end
      // Ack is ignored here: a slave may hold ack high across cycles.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset; a reset aborts any bus cycle at once
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update from pre-edge values.
    if (i_wb_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      data_q    <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign bus.o_cmd_ready = !full;
  assign bus.o_wb_cyc    = cyc_q;
  assign bus.o_wb_stb    = cyc_q;
  assign bus.o_wb_we     = cyc_q;
  assign bus.o_wb_adr    = adr_q;
  assign bus.o_wb_data   = data_q;

  assign o_busy    = !empty || (state_q != ST_IDLE);
  assign o_err     = err_q;
  assign o_err_adr = err_adr_q;
  assign o_wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer (FIFO_DEPTH=4, TIMEOUT=15).
// The slave model acks the valid addresses 0/2/4/6 one cycle after strobe and
// never acks any other address. A stuck mode holds ack high after its first ack.
// A negedge monitor logs every bus cycle: its address, data, high length and
// the low run before it.
module tb_pwm_cfg_sequencer;

  typedef enum {SLV_NORMAL, SLV_STUCK} slv_mode_e;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic        busy, err;
  logic [15:0] err_adr;
  logic [7:0]  wr_cnt;

  pwm_cfg_sequencer_if bus_if ();

  pwm_cfg_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .i_wb_clk  (clk),
    .i_wb_rst  (rst),
    .bus       (bus_if),
    .i_err_clr (err_clr),
    .o_busy    (busy),
    .o_err     (err),
    .o_err_adr (err_adr),
    .o_wr_cnt  (wr_cnt)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: the ack is driven at the negedge, away from the DUT's sampling edge
  slv_mode_e mode = SLV_NORMAL;
  int        age = 0;
  logic      stuck_on = 1'b0;
  logic      hit;
  always @(negedge clk) begin
    if (rst) begin
      age = 0; stuck_on = 1'b0; bus_if.i_wb_ack = 1'b0;
    end else begin
      if (bus_if.o_wb_cyc) age++; else age = 0;
      hit = bus_if.o_wb_cyc && (age == 2) &&
            (bus_if.o_wb_adr[15:3] == 13'd0) && !bus_if.o_wb_adr[0];
      if (mode == SLV_STUCK && hit) stuck_on = 1'b1;
      bus_if.i_wb_ack = hit || stuck_on;
    end
  end

  // Bus monitor
  logic [15:0] adr_log[$], data_log[$];
  int          len_log[$], gap_log[$];
  logic        prev_cyc = 1'b0, seen_fall = 1'b0;
  int          run = 0, low_run = 0, sig_bad = 0;
  always @(negedge clk) begin
    if (bus_if.o_wb_stb !== bus_if.o_wb_cyc || bus_if.o_wb_we !== bus_if.o_wb_cyc) sig_bad++;
    if (bus_if.o_wb_cyc) begin
      if (!prev_cyc) begin
        adr_log.push_back(bus_if.o_wb_adr);
        data_log.push_back(bus_if.o_wb_data);
        if (seen_fall) gap_log.push_back(low_run);
        run = 0;
      end
      run++;
    end else begin
      if (prev_cyc) begin
        len_log.push_back(run);
        seen_fall = 1'b1;
        low_run = 0;
      end
      low_run++;
    end
    prev_cyc = bus_if.o_wb_cyc;
  end

  task automatic clear_log();
    adr_log.delete(); data_log.delete(); len_log.delete(); gap_log.delete();
    seen_fall = 1'b0; low_run = 0; run = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 clear_log();
  endtask

  // Present one command and hold it until it is accepted at a posedge
  task automatic push(input logic [15:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    bus_if.i_cmd_valid = 1'b1; bus_if.i_cmd_adr = a; bus_if.i_cmd_data = d;
    n = 0;
    while (!bus_if.o_cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("push_wait_ready", 32'(n), 32'd0);
    @(posedge clk); #1 bus_if.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_cyc(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus_if.o_wb_cyc && n < 100);
    if (!bus_if.o_wb_cyc) check({tag, "_wait_cyc"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || bus_if.o_wb_cyc) && n < 500);
    if (busy) check({tag, "_wait_idle"}, 32'd1, 32'd0);
  endtask

  logic [15:0] burst_adr [6] = '{16'h0, 16'h2, 16'h4, 16'h6, 16'h0, 16'h2};

  initial begin
    int   n;
    logic err_before;
    bus_if.i_cmd_valid = 1'b0; bus_if.i_cmd_adr = '0; bus_if.i_cmd_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cyc",     32'(bus_if.o_wb_cyc),    32'd0);
    check("rst_adr",     32'(bus_if.o_wb_adr),    32'd0);
    check("rst_data",    32'(bus_if.o_wb_data),   32'd0);
    check("rst_err",     32'(err),                32'd0);
    check("rst_err_adr", 32'(err_adr),            32'd0);
    check("rst_wr_cnt",  32'(wr_cnt),             32'd0);
    check("rst_busy",    32'(busy),               32'd0);
    check("rst_ready",   32'(bus_if.o_cmd_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1 clear_log();

    // Single write: 2-cycle latency, 2 cycles of cyc, GAP, then idle
    push(16'h0002, 16'h0010);
    @(negedge clk);
    check("t1_latency_cyc0", 32'(bus_if.o_wb_cyc), 32'd0);
    @(negedge clk);
    check("t1_cyc_up",  32'(bus_if.o_wb_cyc),  32'd1);
    check("t1_adr",     32'(bus_if.o_wb_adr),  32'h0002);
    check("t1_data",    32'(bus_if.o_wb_data), 32'h0010);
    @(negedge clk);
    check("t1_cyc_2nd", 32'(bus_if.o_wb_cyc),  32'd1);
    @(negedge clk);
    check("t1_cyc_down", 32'(bus_if.o_wb_cyc), 32'd0);
    check("t1_busy_gap", 32'(busy),            32'd1);
    @(negedge clk);
    check("t1_busy_low", 32'(busy),            32'd0);
    check("t1_wr_cnt",   32'(wr_cnt),          32'd1);
    check("t1_err",      32'(err),             32'd0);
    check("t1_len",      32'(len_log.size() > 0 ? len_log[0] : 0), 32'd2);

    // Burst of 6 into a 4-deep FIFO; one entry is held by the sequencer
    do_reset();
    for (int i = 0; i < 5; i++) push(burst_adr[i], 16'h0100 + 16'(i));
    check("t2_ready_full", 32'(bus_if.o_cmd_ready), 32'd0);
    push(burst_adr[5], 16'h0105);
    wait_idle("t2");
    check("t2_count", 32'(adr_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < adr_log.size()) begin
        check($sformatf("t2_adr%0d", i),  32'(adr_log[i]),  32'(burst_adr[i]));
        check($sformatf("t2_data%0d", i), 32'(data_log[i]), 32'h0100 + 32'(i));
        check($sformatf("t2_len%0d", i),  32'(len_log[i]),  32'd2);
      end
    end
    check("t2_gaps", 32'(gap_log.size()), 32'd5);
    foreach (gap_log[i]) check($sformatf("t2_gap%0d", i), 32'(gap_log[i]), 32'd2);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd6);

    // Invalid address times out after exactly 15 cycles; the next command still runs
    do_reset();
    push(16'h0003, 16'hAAAA);
    push(16'h0004, 16'h0044);
    wait_cyc("t3");
    n = 0; err_before = 1'b0;
    while (bus_if.o_wb_cyc && n < 100) begin
      err_before = err;
      @(negedge clk); n++;
    end
    check("t3_cyc_len",      32'(n),          32'd15);
    check("t3_err_before",   32'(err_before), 32'd0);
    check("t3_err_at_fall",  32'(err),        32'd1);
    check("t3_err_adr",      32'(err_adr),    32'h0003);
    wait_idle("t3");
    check("t3_count", 32'(adr_log.size()), 32'd2);
    if (adr_log.size() == 2) begin
      check("t3_adr1", 32'(adr_log[1]), 32'h0004);
      check("t3_len1", 32'(len_log[1]), 32'd2);
    end
    check("t3_wr_cnt", 32'(wr_cnt), 32'd1);

    // Clear in the same cycle as a second timeout: the timeout wins
    push(16'h0005, 16'h0055);
    wait_cyc("t4");
    repeat (14) @(negedge clk);
    check("t4_cyc_last", 32'(bus_if.o_wb_cyc), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_cyc_down",  32'(bus_if.o_wb_cyc), 32'd0);
    check("t4_err_kept",  32'(err),             32'd1);
    check("t4_err_adr",   32'(err_adr),         32'h0005);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("t4_err_clr",     32'(err),     32'd0);
    check("t4_err_adr_hold", 32'(err_adr), 32'h0005);
    wait_idle("t4");

    // Stuck-high ack: each command still gets a BUS cycle and a GAP
    do_reset();
    mode = SLV_STUCK;
    push(16'h0000, 16'h0031);
    push(16'h0002, 16'h0032);
    push(16'h0004, 16'h0033);
    wait_idle("t5");
    check("t5_count", 32'(adr_log.size()), 32'd3);
    if (adr_log.size() == 3) begin
      check("t5_adr0", 32'(adr_log[0]), 32'h0000);
      check("t5_adr1", 32'(adr_log[1]), 32'h0002);
      check("t5_adr2", 32'(adr_log[2]), 32'h0004);
      check("t5_len0", 32'(len_log[0]), 32'd2);
      check("t5_len1", 32'(len_log[1]), 32'd1);
      check("t5_len2", 32'(len_log[2]), 32'd1);
    end
    foreach (gap_log[i]) check($sformatf("t5_gap%0d", i), 32'(gap_log[i]), 32'd2);
    check("t5_wr_cnt", 32'(wr_cnt), 32'd3);
    mode = SLV_NORMAL;

    // Reset mid-BUS with 3 commands queued
    do_reset();
    push(16'h0000, 16'h0001);
    wait_idle("t6a");
    check("t6_pre_wr_cnt", 32'(wr_cnt), 32'd1);
    push(16'h0001, 16'h0011);
    push(16'h0002, 16'h0012);
    push(16'h0004, 16'h0013);
    push(16'h0006, 16'h0014);
    @(negedge clk);
    check("t6_in_bus", 32'(bus_if.o_wb_cyc), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_async_cyc", 32'(bus_if.o_wb_cyc),    32'd0);
    check("t6_ready",     32'(bus_if.o_cmd_ready), 32'd1);
    check("t6_busy",      32'(busy),               32'd0);
    check("t6_wr_cnt",    32'(wr_cnt),             32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 clear_log();
    repeat (10) @(negedge clk);
    check("t6_no_cycle", 32'(adr_log.size()), 32'd0);
    check("t6_idle",     32'(busy),           32'd0);
    push(16'h0002, 16'h0077);
    wait_idle("t6b");
    check("t6_new_count", 32'(adr_log.size()), 32'd1);
    if (adr_log.size() == 1) check("t6_new_adr", 32'(adr_log[0]), 32'h0002);
    check("t6_new_wr_cnt", 32'(wr_cnt), 32'd1);

    check("stb_we_follow_cyc", 32'(sig_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
